fb_rd_arbiter: RTL and testbench
================================

FB_RD_ARBITER -- requirements
Module: fb_rd_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per colour channel; pixel word is DATA_WIDTH*3.
REQ-002 SHALL have parameter TOTAL_BYTES, default 176*240, frame-buffer pixel count.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(TOTAL_BYTES), frame-buffer address width.
REQ-004 SHALL have parameter RD_LATENCY, default 1, frame-buffer read latency in cycles; legal range 1..3.
REQ-005 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port disp_oe  input  1  display read request.
REQ-008 SHALL have port disp_addr  input  ADDR_WIDTH  display read address.
REQ-009 SHALL have port disp_rdata  output  DATA_WIDTH*3  display read data.
REQ-010 SHALL have port disp_rvalid  output  1  display read data valid.
REQ-011 SHALL have port tx_oe  input  1  UART-TX read request.
REQ-012 SHALL have port tx_addr  input  ADDR_WIDTH  UART-TX read address.
REQ-013 SHALL have port tx_gnt  output  1  UART-TX request accepted this cycle.
REQ-014 SHALL have port tx_rdata  output  DATA_WIDTH*3  UART-TX read data.
REQ-015 SHALL have port tx_rvalid  output  1  UART-TX read data valid.
REQ-016 SHALL have ports tx_start, tx_done, vsync  input  1 each  lock request pulse, transfer-complete pulse, frame boundary level.
REQ-017 SHALL have port lock_ready  output  1  one-cycle pulse, frame now frozen.
REQ-018 SHALL have port wr_freeze  output  1  blocks camera writes to frame buffer.
REQ-019 SHALL have ports fb_oe  output  1, fb_addr  output  ADDR_WIDTH, fb_rdata  input  DATA_WIDTH*3  shared frame-buffer read port.

Function
REQ-020 Lock FSM SHALL have states IDLE, WAIT_VS, LOCKED.
REQ-021 IDLE -> WAIT_VS on tx_start; tx_start SHALL be ignored in WAIT_VS and LOCKED.
REQ-022 WAIT_VS -> LOCKED on vsync rising edge (vsync registered once, edge = current & ~previous).
REQ-023 LOCKED -> IDLE on tx_done; tx_done outside LOCKED SHALL be ignored.
REQ-024 wr_freeze SHALL be registered, 1 exactly while state is LOCKED.
REQ-025 lock_ready SHALL pulse 1 cycle, the first cycle state is LOCKED.
REQ-026 Arbitration combinational: disp_oe has strict priority; tx_gnt = tx_oe & ~disp_oe & (state==LOCKED).
REQ-027 fb_oe = disp_oe | tx_gnt; fb_addr = disp_addr if disp_oe else tx_addr.
REQ-028 Per-grant owner tag SHALL traverse an RD_LATENCY-deep shift register; at output, disp_rvalid or tx_rvalid = 1 for exactly one cycle, RD_LATENCY cycles after the grant.
REQ-029 disp_rdata and tx_rdata SHALL both carry fb_rdata directly (no added latency); only rvalid distinguishes owner.
REQ-030 Back-to-back grants SHALL be accepted every cycle; one rvalid per grant, in grant order.
REQ-031 tx_done arriving with reads in flight: pending tx_rvalid SHALL still be delivered.
REQ-032 tx_oe held while not granted: no fb access, tx_gnt 0, requester SHALL hold addr.

Reset
REQ-033 On reset: state IDLE, wr_freeze 0, lock_ready 0, tag pipeline cleared, disp_rvalid 0, tx_rvalid 0, vsync history 0.
REQ-034 Reset mid-transfer SHALL discard in-flight reads with no rvalid after release.

Structure
REQ-035 Lock FSM state enum and owner-tag enum (NONE, DISP, TX) SHALL be in shared package fb_pkg.
REQ-036 Single module; no sub-module required.

Verification
REQ-037 tx_oe=1, addr 5, state IDLE -> tx_gnt 0, fb_oe 0, no tx_rvalid.
REQ-038 tx_start, vsync 0->1 -> LOCKED 2 cycles after edge, lock_ready one pulse, wr_freeze 1; tx_done -> IDLE, wr_freeze 0 next cycle.
REQ-039 LOCKED, disp_oe and tx_oe both 1, addrs 10/20 -> fb_addr 10, tx_gnt 0; disp_oe drops -> fb_addr 20, tx_gnt 1, tx_rvalid RD_LATENCY later.
REQ-040 RD_LATENCY=2, alternating disp/tx grants 4 cycles -> rvalids alternate in order, 2-cycle offset, data matches fb model.
REQ-041 reset asserted with 2 reads in flight -> all outputs 0 immediately, no rvalid after deassert.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer read arbiter: lock FSM states and the
// owner tag that follows each granted read down the latency pipe.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        LOCKED
    } lock_state_t;

    typedef enum logic [1:0] {
        NONE,
        DISP,
        TX
    } owner_t;

endpackage

// File: rtl/fb_rd_arbiter_if.sv
// Read-side bus of the frame-buffer arbiter: display client, UART-TX client
// and the shared frame-buffer read port.
interface fb_rd_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                    disp_oe;
    logic [ADDR_WIDTH-1:0]   disp_addr;
    logic [DATA_WIDTH*3-1:0] disp_rdata;
    logic                    disp_rvalid;

    logic                    tx_oe;
    logic [ADDR_WIDTH-1:0]   tx_addr;
    logic                    tx_gnt;
    logic [DATA_WIDTH*3-1:0] tx_rdata;
    logic                    tx_rvalid;

    logic                    fb_oe;
    logic [ADDR_WIDTH-1:0]   fb_addr;
    logic [DATA_WIDTH*3-1:0] fb_rdata;

    // Arbiter side
    modport slave (
        input  disp_oe, disp_addr, tx_oe, tx_addr, fb_rdata,
        output disp_rdata, disp_rvalid, tx_gnt, tx_rdata, tx_rvalid, fb_oe, fb_addr
    );

    // Clients plus frame-buffer side
    modport master (
        output disp_oe, disp_addr, tx_oe, tx_addr, fb_rdata,
        input  disp_rdata, disp_rvalid, tx_gnt, tx_rdata, tx_rvalid, fb_oe, fb_addr
    );
endinterface

// File: rtl/fb_rd_arbiter.sv
// Shares one frame-buffer read port between the display (strict priority) and
// a UART-TX reader that may only read while the frame is locked against writes.
module fb_rd_arbiter
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TOTAL_BYTES = 176 * 240,
    parameter int ADDR_WIDTH  = $clog2(TOTAL_BYTES),
    parameter int RD_LATENCY  = 1
) (
    input  logic           clk,
    input  logic           reset,
    fb_rd_arbiter_if.slave bus,
    input  logic           tx_start,
    input  logic           tx_done,
    input  logic           vsync,
    output logic           lock_ready,
    output logic           wr_freeze
);

    lock_state_t state_q, state_d;
    logic        vs_q, vs_prev_q;
    logic        vs_rise;
    logic        wr_freeze_q, wr_freeze_d;
    logic        lock_ready_q, lock_ready_d;

    assign vs_rise = vs_q & ~vs_prev_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx_start) state_d = WAIT_VS;
            WAIT_VS: if (vs_rise)  state_d = LOCKED;
            LOCKED:  if (tx_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_freeze_d  = (state_d == LOCKED);
        lock_ready_d = (state_d == LOCKED) && (state_q != LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vs_q         <= 1'b0;
            vs_prev_q    <= 1'b0;
            wr_freeze_q  <= 1'b0;
            lock_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vsync;
            vs_prev_q    <= vs_q;
            wr_freeze_q  <= wr_freeze_d;
            lock_ready_q <= lock_ready_d;
        end
    end

    assign wr_freeze  = wr_freeze_q;
    assign lock_ready = lock_ready_q;

    // Grants are masked during reset so nothing reaches the frame buffer.
    logic                  disp_gnt, tx_gnt;
    logic [ADDR_WIDTH-1:0] addr_mux;
    owner_t                grant_tag;

    assign disp_gnt = bus.disp_oe & ~reset;
    assign tx_gnt   = bus.tx_oe & ~bus.disp_oe & (state_q == LOCKED) & ~reset;
    assign addr_mux = bus.disp_oe ? bus.disp_addr : bus.tx_addr;

    always_comb begin
        grant_tag = NONE;
        if (disp_gnt)    grant_tag = DISP;
        else if (tx_gnt) grant_tag = TX;
    end

    assign bus.tx_gnt  = tx_gnt;
    assign bus.fb_oe   = disp_gnt | tx_gnt;
    assign bus.fb_addr = addr_mux;

    // Owner tag rides alongside the frame-buffer read latency.
    owner_t tag_q [RD_LATENCY:1];
    owner_t tag_d [RD_LATENCY:1];

    always_comb begin
        tag_d[1] = grant_tag;
        for (int i = 2; i <= RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= RD_LATENCY; i++) tag_q[i] <= NONE;
        end else begin
            tag_q <= tag_d;
        end
    end

    logic [DATA_WIDTH*3-1:0] pix;
    assign pix = bus.fb_rdata;

    assign bus.disp_rdata  = pix;
    assign bus.tx_rdata    = pix;
    assign bus.disp_rvalid = (tag_q[RD_LATENCY] == DISP);
    assign bus.tx_rvalid   = (tag_q[RD_LATENCY] == TX);

endmodule

// File: tb/tb_fb_rd_arbiter.sv
// Randomized bench for fb_rd_arbiter: a cycle-level lock/arbitration model
// predicts grants and pushes expected reads; a monitor pops them on rvalid.
module tb_fb_rd_arbiter;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int L  = 2;
    localparam int PW = DW * 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx_start = 1'b0, tx_done = 1'b0, vsync = 1'b0;
    logic lock_ready, wr_freeze;

    fb_rd_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fb_rd_arbiter #(
        .DATA_WIDTH (DW),
        .TOTAL_BYTES(176 * 240),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .vsync     (vsync),
        .lock_ready(lock_ready),
        .wr_freeze (wr_freeze)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] fbf(input logic [AW-1:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'd40503) ^ 32'h00A5C3;
        return h[PW-1:0];
    endfunction

    // Frame-buffer memory: fixed read latency L, contents derived from address.
    logic [PW-1:0] rdp [L];
    always @(posedge clk) begin
        rdp[0] <= bus.fb_oe ? fbf(bus.fb_addr) : '0;
        for (int i = 1; i < L; i++) rdp[i] <= rdp[i-1];
    end
    assign bus.fb_rdata = rdp[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int            owner;  // 1 = display, 2 = uart-tx
        logic [PW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    // Reference model: 0 idle, 1 waiting for vsync, 2 locked
    int m_state;
    bit m_edge, m_vsprev, m_just;

    task automatic model_reset();
        m_state = 0; m_edge = 0; m_vsprev = 0; m_just = 0;
    endtask

    task automatic step(input bit d_oe, input logic [AW-1:0] d_a, input bit t_oe,
                        input logic [AW-1:0] t_a, input bit st, input bit dn, input bit vs);
        bit locked, tg, fo;
        @(posedge clk); #1;
        bus.disp_oe = d_oe; bus.disp_addr = d_a;
        bus.tx_oe = t_oe;   bus.tx_addr = t_a;
        tx_start = st; tx_done = dn; vsync = vs;
        #1;
        locked = (m_state == 2);
        tg = t_oe && !d_oe && locked;
        fo = d_oe || tg;
        check("tx_gnt",     32'(bus.tx_gnt), 32'(tg));
        check("fb_oe",      32'(bus.fb_oe),  32'(fo));
        if (fo) check("fb_addr", 32'(bus.fb_addr), 32'(d_oe ? d_a : t_a));
        check("wr_freeze",  32'(wr_freeze),  32'(locked));
        check("lock_ready", 32'(lock_ready), 32'(m_just));
        if (fo) sbq.push_back('{d_oe ? 1 : 2, fbf(d_oe ? d_a : t_a), cyc + L});
        m_just = 0;
        case (m_state)
            0: if (st) m_state = 1;
            1: if (m_edge) begin m_state = 2; m_just = 1; end
            2: if (dn) m_state = 0;
            default: m_state = 0;
        endcase
        m_edge   = vs && !m_vsprev;
        m_vsprev = vs;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_fb_oe"},       32'(bus.fb_oe),       0);
        check({tag, "_tx_gnt"},      32'(bus.tx_gnt),      0);
        check({tag, "_disp_rvalid"}, 32'(bus.disp_rvalid), 0);
        check({tag, "_tx_rvalid"},   32'(bus.tx_rvalid),   0);
        check({tag, "_wr_freeze"},   32'(wr_freeze),       0);
        check({tag, "_lock_ready"},  32'(lock_ready),      0);
    endtask

    task automatic clear_inputs();
        bus.disp_oe = 0; bus.disp_addr = '0; bus.tx_oe = 0; bus.tx_addr = '0;
        tx_start = 0; tx_done = 0; vsync = 0;
    endtask

    // Monitor: every read-data beat must match the oldest outstanding grant.
    initial begin
        int   own;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.disp_rvalid || bus.tx_rvalid) begin
                own = bus.disp_rvalid ? 1 : 2;
                if (bus.disp_rvalid && bus.tx_rvalid) check("rvalid_onehot", 32'd3, 32'(own));
                if (sbq.size() == 0) begin
                    check("rvalid_unexpected", 32'(own), 0);
                end else begin
                    e = sbq.pop_front();
                    check("rd_owner",   32'(own), 32'(e.owner));
                    check("rd_data",    32'(own == 1 ? bus.disp_rdata : bus.tx_rdata), 32'(e.data));
                    check("rd_shared",  32'(bus.disp_rdata), 32'(bus.tx_rdata));
                    check("rd_latency", 32'(cyc), 32'(e.due));
                end
            end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
                check("rd_missing", 32'(cyc), 32'(sbq[0].due));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit vs_cur;
        clear_inputs();
        #1 reset = 1'b1;
        // Requests present during reset must not reach the frame buffer.
        bus.disp_oe = 1; bus.disp_addr = 16'd3; bus.tx_oe = 1; bus.tx_addr = 16'd4;
        @(posedge clk); #2;
        check_quiet("reset");
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Unlocked tx request is never granted
        repeat (4) step(0, '0, 1, 16'd5, 0, 0, 0);

        // Lock sequence
        step(0, '0, 0, '0, 1, 0, 0);
        repeat (2) step(0, '0, 0, '0, 0, 0, 0);
        repeat (4) step(0, '0, 0, '0, 0, 0, 1);

        // Display priority, then tx takes the port
        repeat (2) step(1, 16'd10, 1, 16'd20, 0, 0, 1);
        repeat (2) step(0, 16'd10, 1, 16'd20, 0, 0, 1);
        repeat (3) step(0, '0, 0, '0, 0, 0, 1);

        // Alternating back-to-back grants
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) step(1, AW'(30 + i), 0, '0, 0, 0, 1);
            else            step(0, '0, 1, AW'(40 + i), 0, 0, 1);
        end
        repeat (3) step(0, '0, 0, '0, 0, 0, 1);

        // tx_done with a tx read still in flight
        step(0, '0, 1, 16'd77, 0, 0, 1);
        step(0, '0, 0, '0, 0, 1, 1);
        repeat (3) step(0, '0, 0, '0, 0, 0, 1);

        // Randomized traffic and lock-control activity
        vs_cur = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) vs_cur = ~vs_cur;
            step($urandom_range(0, 2) == 0, AW'($urandom_range(0, 42239)),
                 $urandom_range(0, 1) == 1, AW'($urandom_range(0, 42239)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, vs_cur);
        end
        repeat (4) step(0, '0, 0, '0, 0, 0, vs_cur);

        // Reset with reads in flight: everything discarded
        step(1, 16'd50, 0, '0, 0, 0, 0);
        step(1, 16'd51, 0, '0, 0, 0, 0);
        #1 reset = 1'b1;
        sbq.delete();
        #1 check_quiet("midreset");
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (6) step(0, '0, 0, '0, 0, 0, 0);

        check("sb_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
